// File: rtl/traffic_light_monitor_if.sv
// Lamp lines from the traffic light controller plus the monitor's status outputs.
// The lamps carry no handshake: the monitor samples all three lines on every rising clk edge.
interface traffic_light_monitor_if;
  logic       RED;
  logic       GREEN;
  logic       YELLOW;
  logic [1:0] phase;
  logic       in_sync;
  logic       fault;
  logic [1:0] fault_code;
  logic [7:0] cycle_count;
  logic [2:0] state_dbg;

  modport master (
    output RED, GREEN, YELLOW,
    input  phase, in_sync, fault, fault_code, cycle_count, state_dbg
  );

  modport slave (
    input  RED, GREEN, YELLOW,
    output phase, in_sync, fault, fault_code, cycle_count, state_dbg
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Checks the RED->GREEN->YELLOW->RED lamp sequence and per-phase durations,
// latching a sticky fault with the cause of the first violation.
module traffic_light_monitor #(
  parameter int Time_RED    = 20,
  parameter int Time_GREEN  = 15,
  parameter int Time_YELLOW = 5,
  parameter int CNT_W       = 8
) (
  input logic                    clk,
  input logic                    rs,
  traffic_light_monitor_if.slave bus
);

  typedef enum logic [2:0] {
    S_SYNC, S_MON_RED, S_MON_GREEN, S_MON_YELLOW, S_FAULT
  } state_t;

  localparam logic [CNT_W-1:0] LEN_RED    = CNT_W'(Time_RED + 1);
  localparam logic [CNT_W-1:0] LEN_GREEN  = CNT_W'(Time_GREEN + 1);
  localparam logic [CNT_W-1:0] LEN_YELLOW = CNT_W'(Time_YELLOW + 1);

  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_GREEN  = 3'b010;
  localparam logic [2:0] L_YELLOW = 3'b001;

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_cnt, w_cnt_n;
  logic [1:0]       r_phase, w_phase_n;
  logic             r_in_sync, w_in_sync_n;
  logic             r_fault, w_fault_n;
  logic [1:0]       r_code, w_code_n;
  logic [7:0]       r_cycles, w_cycles_n;
  logic [2:0]       r_prev;

  logic [2:0]       w_lamp;
  logic             w_legal;
  logic [2:0]       w_self;
  logic [2:0]       w_succ;
  state_t           w_succ_state;
  logic [1:0]       w_succ_phase;
  logic [CNT_W-1:0] w_len;

  assign w_lamp  = {bus.RED, bus.GREEN, bus.YELLOW};
  assign w_legal = (w_lamp == L_RED) || (w_lamp == L_GREEN) || (w_lamp == L_YELLOW);

  always_comb begin
    w_self       = L_RED;
    w_succ       = L_GREEN;
    w_succ_state = S_MON_GREEN;
    w_succ_phase = 2'b10;
    w_len        = LEN_RED;
    case (r_state)
      S_MON_GREEN: begin
        w_self       = L_GREEN;
        w_succ       = L_YELLOW;
        w_succ_state = S_MON_YELLOW;
        w_succ_phase = 2'b11;
        w_len        = LEN_GREEN;
      end
      S_MON_YELLOW: begin
        w_self       = L_YELLOW;
        w_succ       = L_RED;
        w_succ_state = S_MON_RED;
        w_succ_phase = 2'b01;
        w_len        = LEN_YELLOW;
      end
      default: ;
    endcase
  end

  // Priority within one sample: lamp legality, then sequence order, then timing.
  always_comb begin
    w_state_n  = r_state;
    w_cnt_n    = r_cnt;
    w_phase_n  = r_phase;
    w_fault_n  = r_fault;
    w_code_n   = r_code;
    w_cycles_n = r_cycles;
    if (r_state != S_FAULT) begin
      if (!w_legal) begin
        w_state_n = S_FAULT;
        w_fault_n = 1'b1;
        w_code_n  = 2'b01;
      end else if (r_state == S_SYNC) begin
        if (r_prev == L_RED && w_lamp == L_GREEN) begin
          w_state_n = S_MON_GREEN;
          w_cnt_n   = CNT_W'(1);
          w_phase_n = 2'b10;
        end
      end else if (w_lamp == w_self) begin
        if (r_cnt == w_len) begin
          w_state_n = S_FAULT;
          w_fault_n = 1'b1;
          w_code_n  = 2'b11;
        end else begin
          w_cnt_n = r_cnt + CNT_W'(1);
        end
      end else if (w_lamp == w_succ) begin
        if (r_cnt != w_len) begin
          w_state_n = S_FAULT;
          w_fault_n = 1'b1;
          w_code_n  = 2'b11;
        end else begin
          w_state_n = w_succ_state;
          w_cnt_n   = CNT_W'(1);
          w_phase_n = w_succ_phase;
          if (r_state == S_MON_YELLOW) w_cycles_n = r_cycles + 8'd1;
        end
      end else begin
        w_state_n = S_FAULT;
        w_fault_n = 1'b1;
        w_code_n  = 2'b10;
      end
    end
    w_in_sync_n = (w_state_n == S_MON_RED) || (w_state_n == S_MON_GREEN) ||
                  (w_state_n == S_MON_YELLOW);
  end

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      r_state   <= S_SYNC;
      r_cnt     <= '0;
      r_phase   <= 2'b00;
      r_in_sync <= 1'b0;
      r_fault   <= 1'b0;
      r_code    <= 2'b00;
      r_cycles  <= 8'd0;
      r_prev    <= 3'b000;
    end else begin
      r_state   <= w_state_n;
      r_cnt     <= w_cnt_n;
      r_phase   <= w_phase_n;
      r_in_sync <= w_in_sync_n;
      r_fault   <= w_fault_n;
      r_code    <= w_code_n;
      r_cycles  <= w_cycles_n;
      r_prev    <= w_lamp;
    end
  end

  assign bus.phase       = r_phase;
  assign bus.in_sync     = r_in_sync;
  assign bus.fault       = r_fault;
  assign bus.fault_code  = r_code;
  assign bus.cycle_count = r_cycles;
  assign bus.state_dbg   = r_state;

endmodule
